// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Issues a start strobe, then acks on busy-rise or drops the byte on start timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic [NREQ-1:0]   grant,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    output logic              arb_busy
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d, err_q, err_d;
    logic            tx_en_q, tx_en_d, arb_busy_q;
    logic [7:0]      data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]   last_q, last_d, owner_q, owner_d, win_idx;
    logic            win_vld, timeout;
    int unsigned     cand;

    // First set request searching last+1, last+2, ... modulo NREQ
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_q) + k) % NREQ;
            if (!win_vld && req[IW'(cand)]) begin
                win_vld = 1'b1;
                win_idx = IW'(cand);
            end
        end
    end

    // Saturating start-timeout counter
    assign cnt_inc = (cnt_q == CW'(START_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    assign timeout = (cnt_inc == CW'(START_TIMEOUT));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (win_vld && !uart_tx_busy) state_d = ISSUE;
            ISSUE:     if (uart_tx_busy)             state_d = WAIT_DONE;
                       else if (timeout)             state_d = IDLE;
            WAIT_DONE: if (!uart_tx_busy)            state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        ack_d   = '0;
        err_d   = '0;
        tx_en_d = tx_en_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld && !uart_tx_busy) begin
                    grant_d = NREQ'(1) << win_idx;
                    data_d  = req_data[{win_idx, 3'b000} +: 8];
                    tx_en_d = 1'b1;
                    cnt_d   = '0;
                    owner_d = win_idx;
                end
            end
            ISSUE: begin
                if (uart_tx_busy) begin
                    tx_en_d = 1'b0;
                    ack_d   = NREQ'(1) << owner_q;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout) begin
                        tx_en_d = 1'b0;
                        err_d   = NREQ'(1) << owner_q;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                grant_d = '0;
                tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            tx_en_q    <= 1'b0;
            data_q     <= 8'h00;
            cnt_q      <= '0;
            last_q     <= IW'(NREQ - 1);
            owner_q    <= '0;
            arb_busy_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tx_en_q    <= tx_en_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            arb_busy_q <= (state_d != IDLE);
        end
    end

    assign grant        = grant_q;
    assign ack          = ack_q;
    assign err          = err_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = data_q;
    assign arb_busy     = arb_busy_q;

endmodule
